// File: rtl/fpu_mult_arbiter_if.sv
// Bundle between the FPU requesters, the shared mantissa multiplier and
// the response consumer. The arbiter takes the slave view; the surrounding
// environment (requesters, multiplier core, consumer) takes the master view.
interface fpu_mult_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 6
);
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned P_W  = 2 * WIDTH;

  // requester side
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;

  // multiplier side
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [P_W-1:0]        mul_result;

  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [P_W-1:0]        rsp_result;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/fpu_mult_arbiter.sv
// Round-robin arbiter / sequencer sharing one iterative mantissa multiplier
// among NREQ FPU requesters. One transaction at a time:
// IDLE (grant) -> ISSUE (start pulse) -> WAIT (for done) -> RESP (handshake).
// Optional feature macro: FPU_MULT_ARB_TIMEOUT_EN aborts a WAIT that lasts
// TIMEOUT cycles, answering with rsp_err=1 and a zero product.
module fpu_mult_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic               clk,
  input  logic               rstn,
  fpu_mult_arbiter_if.slave  bus
);

  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned P_W  = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  id_q,         id_d;
  logic [WIDTH-1:0] mul_a_q,      mul_a_d;
  logic [WIDTH-1:0] mul_b_q,      mul_b_d;
  logic             mul_start_q,  mul_start_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [P_W-1:0]   rsp_result_q, rsp_result_d;
  logic             rsp_err_q,    rsp_err_d;

  logic             grant_found_c;
  logic [ID_W-1:0]  grant_id_c;
  logic [NREQ-1:0]  req_ready_c;
  logic [WIDTH-1:0] op_a_c [NREQ];
  logic [WIDTH-1:0] op_b_c [NREQ];

`ifdef FPU_MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  // TIMEOUT only sizes the abort counter, which this build leaves out
  logic unused_timeout_c;
  assign unused_timeout_c = ^32'(TIMEOUT);
`endif

  // Unpack the flat operand buses into per-requester words
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a_c[g] = bus.req_a[g*WIDTH +: WIDTH];
    assign op_b_c[g] = bus.req_b[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first valid requester after the last one served
  always_comb begin
    int unsigned cand;
    cand          = 0;
    grant_found_c = 1'b0;
    grant_id_c    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(last_grant_q) + 32'd1 + k) % NREQ;
      if (!grant_found_c && bus.req_valid[ID_W'(cand)]) begin
        grant_found_c = 1'b1;
        grant_id_c    = ID_W'(cand);
      end
    end
  end

  // Accept strobe: only the winner, only while idle
  always_comb begin
    req_ready_c = '0;
    if (state_q == ST_IDLE && grant_found_c) begin
      req_ready_c[grant_id_c] = 1'b1;
    end
  end

  // Held at zero while reset is asserted so no grant leaks out of reset
  assign bus.req_ready = rstn ? req_ready_c : '0;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
`ifdef FPU_MULT_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_found_c) begin
          id_d        = grant_id_c;
          mul_a_d     = op_a_c[grant_id_c];
          mul_b_d     = op_b_c[grant_id_c];
          mul_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef FPU_MULT_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_WAIT: begin
        if (bus.mul_done) begin
          rsp_result_d = bus.mul_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
`ifdef FPU_MULT_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = id_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NREQ - 1);
      id_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_start_q  <= mul_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef FPU_MULT_ARB_TIMEOUT_EN
  // WAIT-phase cycle counter for the abort path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign bus.mul_start  = mul_start_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Directed bench for fpu_mult_arbiter with a behavioural multiplier and a
// response scoreboard. Honours FPU_MULT_ARB_TIMEOUT_EN for the abort case.
module tb_fpu_mult_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 6;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] res;
    logic        err;
  } exp_t;

  logic clk;
  logic rstn;

  fpu_mult_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  fpu_mult_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(31)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];
  int           mul_lat  = 6;
  bit           mul_hang = 1'b0;
  int           mdl_cnt  = 0;
  logic [W-1:0] mdl_a;
  logic [W-1:0] mdl_b;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign bus.req_a[g*W +: W] = a_arr[g];
    assign bus.req_b[g*W +: W] = b_arr[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [11:0] res, input logic err);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input logic [1:0] i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_arr[i] = a;
    b_arr[i] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp_oh);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready === 4'b0000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.req_ready), 32'(exp_oh));
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1;
  endtask

  // Behavioural multiplier: done pulse mul_lat cycles after the start pulse
  initial begin
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (mdl_cnt != 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          bus.mul_done   = 1'b1;
          bus.mul_result = 12'(mdl_a) * 12'(mdl_b);
        end
      end else if (bus.mul_start === 1'b1 && !mul_hang) begin
        mdl_a   = bus.mul_a;
        mdl_b   = bus.mul_b;
        mdl_cnt = mul_lat;
      end
    end
  end

  // Scoreboard: compare each response at its handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_rsp_id",     32'(bus.rsp_id),     32'(e.id));
          check("sb_rsp_result", 32'(bus.rsp_result), 32'(e.res));
          check("sb_rsp_err",    32'(bus.rsp_err),    32'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_req_ready",  32'(bus.req_ready),  32'd0);
    check("rst_mul_start",  32'(bus.mul_start),  32'd0);
    check("rst_mul_a",      32'(bus.mul_a),      32'd0);
    check("rst_mul_b",      32'(bus.mul_b),      32'd0);
    check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("rst_rsp_id",     32'(bus.rsp_id),     32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
    rstn = 1'b1;
    accept_edge();

    // Single request, latency L=6: rsp_valid seen at T+8
    mul_lat = 6;
    set_req(2'd0, 6'd7, 6'd5);
    push_exp(2'd0, 12'd35, 1'b0);
    wait_grant("t1_grant", 4'b0001);
    accept_edge();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_mul_start", 32'(bus.mul_start), 32'd1);
    check("t1_mul_a",     32'(bus.mul_a),     32'd7);
    check("t1_mul_b",     32'(bus.mul_b),     32'd5);
    @(negedge clk);
    check("t1_start_pulse", 32'(bus.mul_start), 32'd0);
    repeat (5) @(negedge clk);
    check("t1_not_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_latency",    32'(bus.rsp_valid),  32'd1);
    check("t1_rsp_id",     32'(bus.rsp_id),     32'd0);
    check("t1_rsp_result", 32'(bus.rsp_result), 32'd35);
    check("t1_rsp_err",    32'(bus.rsp_err),    32'd0);
    drain("t1_drain");
    accept_edge();

    // Max operands, requester 3
    mul_lat = 2;
    set_req(2'd3, 6'd63, 6'd63);
    push_exp(2'd3, 12'd3969, 1'b0);
    wait_grant("t5_grant", 4'b1000);
    accept_edge();
    bus.req_valid[3] = 1'b0;
    wait_rsp("t5_rsp");
    check("t5_result", 32'(bus.rsp_result), 32'd3969);
    drain("t5_drain");
    accept_edge();

    // All four held: round-robin order 0,1,2,3,0
    mul_lat = 3;
    for (int i = 0; i < 4; i++) begin
      set_req(2'(i), 6'(i + 2), 6'(i + 9));
    end
    push_exp(2'd0, 12'd18, 1'b0);
    push_exp(2'd1, 12'd30, 1'b0);
    push_exp(2'd2, 12'd44, 1'b0);
    push_exp(2'd3, 12'd60, 1'b0);
    push_exp(2'd0, 12'd18, 1'b0);
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("t2_grant%0d", g), 4'(1 << (g % 4)));
      accept_edge();
      if (g == 4) bus.req_valid = '0;
      @(negedge clk);
      check($sformatf("t2_ready_oneshot%0d", g), 32'(bus.req_ready), 32'd0);
    end
    drain("t2_drain");
    accept_edge();

    // Response stall with requester 1 waiting
    bus.rsp_ready = 1'b0;
    set_req(2'd2, 6'd9, 6'd9);
    push_exp(2'd2, 12'd81, 1'b0);
    wait_grant("t3_grant2", 4'b0100);
    accept_edge();
    bus.req_valid[2] = 1'b0;
    set_req(2'd1, 6'd10, 6'd11);
    push_exp(2'd1, 12'd110, 1'b0);
    wait_rsp("t3_rsp");
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid",  32'(bus.rsp_valid),  32'd1);
      check("t3_hold_id",     32'(bus.rsp_id),     32'd2);
      check("t3_hold_result", 32'(bus.rsp_result), 32'd81);
      check("t3_no_grant",    32'(bus.req_ready),  32'd0);
      @(negedge clk);
    end
    accept_edge();
    bus.rsp_ready = 1'b1;
    wait_grant("t3_grant1_after", 4'b0010);
    accept_edge();
    bus.req_valid[1] = 1'b0;
    drain("t3_drain");
    accept_edge();

    // Reset during WAIT aborts; first grant afterwards is requester 0
    mul_lat = 10;
    set_req(2'd2, 6'd3, 6'd4);
    wait_grant("t4_grant2", 4'b0100);
    accept_edge();
    bus.req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    check("t4_rst_mul_start",  32'(bus.mul_start),  32'd0);
    check("t4_rst_mul_a",      32'(bus.mul_a),      32'd0);
    check("t4_rst_mul_b",      32'(bus.mul_b),      32'd0);
    check("t4_rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("t4_rst_rsp_id",     32'(bus.rsp_id),     32'd0);
    check("t4_rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("t4_rst_rsp_err",    32'(bus.rsp_err),    32'd0);
    accept_edge();
    rstn = 1'b1;
    begin
      int n;
      n = 0;
      while (mdl_cnt != 0 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) begin
      @(negedge clk);
      check("t4_late_done_ignored", 32'(bus.rsp_valid), 32'd0);
    end
    accept_edge();
    set_req(2'd0, 6'd1, 6'd60);
    set_req(2'd2, 6'd5, 6'd5);
    set_req(2'd3, 6'd6, 6'd6);
    push_exp(2'd0, 12'd60, 1'b0);
    wait_grant("t4_first_grant", 4'b0001);
    accept_edge();
    bus.req_valid = '0;
    drain("t4_drain");
    accept_edge();

    // Multiplier never answers
    mul_hang = 1'b1;
    set_req(2'd1, 6'd2, 6'd3);
`ifdef FPU_MULT_ARB_TIMEOUT_EN
    push_exp(2'd1, 12'd0, 1'b1);
`endif
    wait_grant("t6_grant1", 4'b0010);
    accept_edge();
    bus.req_valid[1] = 1'b0;
`ifdef FPU_MULT_ARB_TIMEOUT_EN
    repeat (32) @(negedge clk);
    check("t6_not_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("t6_timeout_valid",  32'(bus.rsp_valid),  32'd1);
    check("t6_timeout_err",    32'(bus.rsp_err),    32'd1);
    check("t6_timeout_result", 32'(bus.rsp_result), 32'd0);
    drain("t6_drain");
    mul_hang = 1'b0;
`else
    repeat (40) @(negedge clk);
    check("t6_stuck_wait", 32'(bus.rsp_valid), 32'd0);
    accept_edge();
    set_req(2'd2, 6'd2, 6'd3);
    repeat (3) begin
      @(negedge clk);
      check("t6_stuck_no_grant", 32'(bus.req_ready), 32'd0);
    end
    accept_edge();
    rstn = 1'b0;
    bus.req_valid = '0;
    accept_edge();
    rstn = 1'b1;
    mul_hang = 1'b0;
`endif
    accept_edge();

    // Next transaction after the hang issues normally
    mul_lat = 4;
    set_req(2'd2, 6'd2, 6'd3);
    push_exp(2'd2, 12'd6, 1'b0);
    wait_grant("t6_next_grant", 4'b0100);
    accept_edge();
    bus.req_valid[2] = 1'b0;
    drain("t6_next_drain");
    repeat (3) @(negedge clk);
    check("final_no_pending", 32'(bus.rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
